exec_ctrl: RTL and testbench

- Parametrised run/halt/single-step controller for the CPU datapath.
- Replaces the latch-based clock gating with a registered clock enable, o_clkEn, that every sequential datapath unit qualifies on.
- Adds a debounced step/resume button, multi-cycle single-step, a PC breakpoint, a halt-cause report and an enabled-cycle counter.

---
 rtl/exec_ctrl.sv | 177 +++++++++++++++++
 tb/tb_exec_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// exec_ctrl: run/halt/single-step controller driving the datapath clock enable.
// Debounced button, multi-cycle step, PC breakpoint, halt cause, enabled-cycle counter.
module exec_ctrl #(
   parameter int ADDR_WIDTH      = 8,
   parameter int STEP_WIDTH      = 8,
   parameter int CNT_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                  i_clk,
   input  logic                  i_nReset,
   input  logic                  i_ctrlHlt,
   input  logic                  i_button,
   input  logic                  i_stepMode,
   input  logic [STEP_WIDTH-1:0] i_stepCount,
   input  logic [ADDR_WIDTH-1:0] i_pcAddr,
   input  logic [ADDR_WIDTH-1:0] i_bpAddr,
   input  logic                  i_bpEn,
   output logic                  o_clkEn,
   output logic                  o_halted,
   output logic [1:0]            o_haltCause,
   output logic [CNT_WIDTH-1:0]  o_cycleCount
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_HLT  = 2'b01;
   localparam logic [1:0] CAUSE_BP   = 2'b10;
   localparam logic [1:0] CAUSE_STEP = 2'b11;

   // bit 0 is the halted flag so the clock enable comes straight off a flop
   typedef enum logic [1:0] {
      RUN  = 2'b00,
      HALT = 2'b01,
      STEP = 2'b10
   } state_t;

   state_t                state;
   state_t                stateNext;
   logic [1:0]            causeNext;
   logic                  stepLoad;
   logic                  sync1;
   logic                  sync2;
   logic                  dbLevel;
   logic                  dbPrev;
   logic [DB_W-1:0]       dbCnt;
   logic                  press;
   logic [STEP_WIDTH-1:0] stepCnt;
   logic [STEP_WIDTH-1:0] stepLoadVal;
   logic                  bpArmed;
   logic                  pcMatch;
   logic                  bpHit;

   assign press       = dbLevel & ~dbPrev;
   assign pcMatch     = (i_pcAddr == i_bpAddr);
   assign bpHit       = i_bpEn & bpArmed & pcMatch;
   assign stepLoadVal = (i_stepCount == '0) ? STEP_WIDTH'(1) : i_stepCount;

   // two-flop synchroniser for the raw button
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= i_button;
         sync2 <= sync1;
      end
   end

   // accept a new level only after it has been stable long enough
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         dbLevel <= 1'b0;
         dbPrev  <= 1'b0;
         dbCnt   <= '0;
      end else begin
         dbPrev <= dbLevel;
         if (sync2 == dbLevel) begin
            dbCnt <= '0;
         end else if (dbCnt == DB_LAST) begin
            dbLevel <= sync2;
            dbCnt   <= '0;
         end else begin
            dbCnt <= dbCnt + DB_W'(1);
         end
      end
   end

   // state and halt-cause registers
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         state       <= RUN;
         o_haltCause <= CAUSE_NONE;
      end else begin
         state       <= stateNext;
         o_haltCause <= causeNext;
      end
   end

   // next-state and halt-cause selection
   always_comb begin
      stateNext = state;
      causeNext = o_haltCause;
      stepLoad  = 1'b0;
      unique case (state)
         RUN: begin
            if (i_ctrlHlt) begin
               stateNext = HALT;
               causeNext = CAUSE_HLT;
            end else if (bpHit) begin
               stateNext = HALT;
               causeNext = CAUSE_BP;
            end
         end
         HALT: begin
            if (press) begin
               causeNext = CAUSE_NONE;
               stateNext = i_stepMode ? STEP : RUN;
               stepLoad  = i_stepMode;
            end
         end
         STEP: begin
            if (i_ctrlHlt) begin
               stateNext = HALT;
               causeNext = CAUSE_HLT;
            end else if (bpHit) begin
               stateNext = HALT;
               causeNext = CAUSE_BP;
            end else if (stepCnt == STEP_WIDTH'(1)) begin
               stateNext = HALT;
               causeNext = CAUSE_STEP;
            end
         end
         default: stateNext = RUN;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      o_clkEn  = ~state[0];
      o_halted = state[0];
   end

   // step down-counter: load on step entry, count while stepping
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         stepCnt <= '0;
      end else if (stepLoad) begin
         stepCnt <= stepLoadVal;
      end else if (state == STEP) begin
         stepCnt <= stepCnt - STEP_WIDTH'(1);
      end
   end

   // disarm on a breakpoint halt; re-arm once the PC moves away
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         bpArmed <= 1'b1;
      end else if (!pcMatch) begin
         bpArmed <= 1'b1;
      end else if (state != HALT && stateNext == HALT &&
                   causeNext == CAUSE_BP) begin
         bpArmed <= 1'b0;
      end
   end

   // saturating count of enabled cycles
   always_ff @(posedge i_clk or negedge i_nReset) begin
      if (!i_nReset) begin
         o_cycleCount <= '0;
      end else if (o_clkEn && o_cycleCount != '1) begin
         o_cycleCount <= o_cycleCount + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed and randomized checks of exec_ctrl against
// a behavioural model of run/halt/step, debounce and breakpoint rules.
module tb_exec_ctrl;

   localparam int AW = 8;
   localparam int SW = 8;
   localparam int DB = 4;

   logic          i_clk = 1'b0;
   logic          i_nReset;
   logic          i_ctrlHlt;
   logic          i_button;
   logic          i_stepMode;
   logic [SW-1:0] i_stepCount;
   logic [AW-1:0] i_pcAddr;
   logic [AW-1:0] i_bpAddr;
   logic          i_bpEn;
   logic          clkEn;
   logic          halted;
   logic [1:0]    cause;
   logic [15:0]   cnt;
   logic          satClkEn;
   logic          satHalted;
   logic [1:0]    satCause;
   logic [3:0]    satCnt;

   int total = 0;
   int bad = 0;

   // behavioural model state
   bit         m1, m2, mLevel, mPrev, mHalted, mArmed;
   int         mDiff, mSteps, mEnabled;
   logic [1:0] mCause;

   exec_ctrl #(
      .ADDR_WIDTH(AW), .STEP_WIDTH(SW),
      .CNT_WIDTH(16), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clk(i_clk), .i_nReset(i_nReset), .i_ctrlHlt(i_ctrlHlt),
      .i_button(i_button), .i_stepMode(i_stepMode),
      .i_stepCount(i_stepCount), .i_pcAddr(i_pcAddr),
      .i_bpAddr(i_bpAddr), .i_bpEn(i_bpEn), .o_clkEn(clkEn),
      .o_halted(halted), .o_haltCause(cause), .o_cycleCount(cnt)
   );

   exec_ctrl #(
      .ADDR_WIDTH(AW), .STEP_WIDTH(SW),
      .CNT_WIDTH(4), .DEBOUNCE_CYCLES(DB)
   ) dutSat (
      .i_clk(i_clk), .i_nReset(i_nReset), .i_ctrlHlt(i_ctrlHlt),
      .i_button(i_button), .i_stepMode(i_stepMode),
      .i_stepCount(i_stepCount), .i_pcAddr(i_pcAddr),
      .i_bpAddr(i_bpAddr), .i_bpEn(i_bpEn), .o_clkEn(satClkEn),
      .o_halted(satHalted), .o_haltCause(satCause),
      .o_cycleCount(satCnt)
   );

   always #5 i_clk = ~i_clk;

   function void modelReset();
      m1 = 0; m2 = 0; mLevel = 0; mPrev = 0;
      mHalted = 0; mArmed = 1;
      mDiff = 0; mSteps = 0; mEnabled = 0;
      mCause = 2'b00;
   endfunction

   // one clock edge of the controller, from pre-edge inputs
   function void modelStep();
      bit press, hit, s;
      press = mLevel && !mPrev;
      hit = i_bpEn && mArmed && (i_pcAddr == i_bpAddr);
      s = m2;
      if (!mHalted) begin
         mEnabled++;
         if (i_ctrlHlt) begin
            mHalted = 1; mCause = 2'b01; mSteps = 0;
         end else if (hit) begin
            mHalted = 1; mCause = 2'b10; mSteps = 0; mArmed = 0;
         end else if (mSteps > 0) begin
            mSteps--;
            if (mSteps == 0) begin
               mHalted = 1; mCause = 2'b11;
            end
         end
      end else if (press) begin
         mHalted = 0;
         mCause = 2'b00;
         if (!i_stepMode) mSteps = 0;
         else if (i_stepCount == 0) mSteps = 1;
         else mSteps = int'(i_stepCount);
      end
      if (i_pcAddr != i_bpAddr) mArmed = 1;
      mPrev = mLevel;
      if (s == mLevel) mDiff = 0;
      else begin
         mDiff++;
         if (mDiff == DB) begin
            mLevel = s; mDiff = 0;
         end
      end
      m2 = m1;
      m1 = i_button;
   endfunction

   function automatic int expCnt(int w);
      int lim;
      lim = (1 << w) - 1;
      return (mEnabled > lim) ? lim : mEnabled;
   endfunction

   task tick();
      @(posedge i_clk);
      modelStep();
      #1;
   endtask

   task applyReset();
      i_ctrlHlt = 0; i_button = 0; i_stepMode = 0;
      i_stepCount = 8'd1; i_pcAddr = 8'h00;
      i_bpAddr = 8'hFF; i_bpEn = 0;
      i_nReset = 0;
      modelReset();
      @(negedge i_clk);
      i_nReset = 1;
   endtask

   task test_reset();
      applyReset();
      total++;
      if (clkEn !== 1'b1) begin
         bad++; $display("FAIL rst_clkEn got=%0b want=1", clkEn);
      end
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL rst_halted got=%0b want=0", halted);
      end
      total++;
      if (cause !== 2'b00) begin
         bad++; $display("FAIL rst_cause got=%0b want=00", cause);
      end
      total++;
      if (cnt !== 16'd0) begin
         bad++; $display("FAIL rst_cnt got=%0d want=0", cnt);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         total++;
         if (clkEn !== 1'b1) begin
            bad++; $display("FAIL run_clkEn cyc=%0d got=%0b want=1", k, clkEn);
         end
      end
      total++;
      if (cnt !== 16'd10) begin
         bad++; $display("FAIL run_cnt got=%0d want=10", cnt);
      end
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL run_halted got=%0b want=0", halted);
      end
   endtask

   task test_hlt();
      applyReset();
      repeat (5) tick();
      i_ctrlHlt = 1;
      tick();
      i_ctrlHlt = 0;
      total++;
      if (clkEn !== 1'b0) begin
         bad++; $display("FAIL hlt_clkEn got=%0b want=0", clkEn);
      end
      total++;
      if (cause !== 2'b01) begin
         bad++; $display("FAIL hlt_cause got=%0b want=01", cause);
      end
      total++;
      if (cnt !== 16'd6) begin
         bad++; $display("FAIL hlt_cnt got=%0d want=6", cnt);
      end
      repeat (4) tick();
      total++;
      if (cnt !== 16'd6 || clkEn !== 1'b0) begin
         bad++; $display("FAIL hlt_frozen got=%0d/%0b want=6/0", cnt, clkEn);
      end
   endtask

   task test_debounce();
      i_button = 1;
      repeat (3) tick();
      i_button = 0;
      repeat (12) tick();
      total++;
      if (halted !== 1'b1) begin
         bad++; $display("FAIL glitch_halted got=%0b want=1", halted);
      end
      i_stepMode = 0;
      i_button = 1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         total++;
         if (halted !== (k < 7)) begin
            bad++;
            $display("FAIL press_timing edge=%0d got=%0b want=%0b", k, halted, k < 7);
         end
      end
      total++;
      if (cause !== 2'b00) begin
         bad++; $display("FAIL resume_cause got=%0b want=00", cause);
      end
      repeat (3) tick();
      i_button = 0;
      repeat (10) tick();
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL release_halted got=%0b want=0", halted);
      end
   endtask

   task test_step();
      int counts[2];
      int en, want;
      counts[0] = 3;
      counts[1] = 0;
      i_ctrlHlt = 1;
      tick();
      i_ctrlHlt = 0;
      foreach (counts[j]) begin
         want = (counts[j] == 0) ? 1 : counts[j];
         i_stepMode = 1;
         i_stepCount = SW'(counts[j]);
         i_button = 1;
         en = 0;
         for (int k = 1; k <= 40; k++) begin
            tick();
            if (clkEn) en++;
            if (k == 8) i_stepCount = 8'd9;
            if (k == 10) i_button = 0;
         end
         total++;
         if (en !== want) begin
            bad++; $display("FAIL step_len n=%0d got=%0d want=%0d", counts[j], en, want);
         end
         total++;
         if (halted !== 1'b1 || cause !== 2'b11) begin
            bad++;
            $display("FAIL step_cause n=%0d got=%0b/%0b want=1/11", counts[j], halted, cause);
         end
      end
   endtask

   task test_breakpoint();
      applyReset();
      i_bpEn = 1;
      i_bpAddr = 8'h12;
      i_pcAddr = 8'h10;
      tick();
      i_pcAddr = 8'h11;
      tick();
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL bp_early got=%0b want=0", halted);
      end
      i_pcAddr = 8'h12;
      tick();
      total++;
      if (halted !== 1'b1 || cause !== 2'b10) begin
         bad++; $display("FAIL bp_hit got=%0b/%0b want=1/10", halted, cause);
      end
      total++;
      if (cnt !== 16'd3) begin
         bad++; $display("FAIL bp_cnt got=%0d want=3", cnt);
      end
      i_stepMode = 0;
      i_button = 1;
      repeat (10) tick();
      i_button = 0;
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL bp_resume got=%0b want=0", halted);
      end
      repeat (8) tick();
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL bp_no_rehalt got=%0b want=0", halted);
      end
      i_pcAddr = 8'h13;
      tick();
      i_pcAddr = 8'h12;
      tick();
      total++;
      if (halted !== 1'b1 || cause !== 2'b10) begin
         bad++; $display("FAIL bp_again got=%0b/%0b want=1/10", halted, cause);
      end
   endtask

   task test_step_priority();
      i_bpAddr = 8'h40;
      i_pcAddr = 8'h41;
      tick();
      i_stepMode = 1;
      i_stepCount = 8'd5;
      i_button = 1;
      repeat (7) tick();
      total++;
      if (clkEn !== 1'b1) begin
         bad++; $display("FAIL prio_in_step got=%0b want=1", clkEn);
      end
      i_ctrlHlt = 1;
      i_pcAddr = 8'h40;
      tick();
      i_ctrlHlt = 0;
      total++;
      if (halted !== 1'b1 || cause !== 2'b01) begin
         bad++; $display("FAIL prio_cause got=%0b/%0b want=1/01", halted, cause);
      end
      i_button = 0;
      i_pcAddr = 8'h41;
      repeat (10) tick();
   endtask

   task test_reset_mid_step();
      i_stepMode = 1;
      i_stepCount = 8'd5;
      i_button = 1;
      repeat (8) tick();
      total++;
      if (clkEn !== 1'b1) begin
         bad++; $display("FAIL mid_in_step got=%0b want=1", clkEn);
      end
      i_button = 0;
      #2;
      i_nReset = 0;
      modelReset();
      #1;
      total++;
      if (clkEn !== 1'b1 || halted !== 1'b0) begin
         bad++; $display("FAIL mid_rst_state got=%0b/%0b want=1/0", clkEn, halted);
      end
      total++;
      if (cnt !== 16'd0) begin
         bad++; $display("FAIL mid_rst_cnt got=%0d want=0", cnt);
      end
      @(negedge i_clk);
      i_nReset = 1;
      repeat (10) tick();
      total++;
      if (halted !== 1'b0 || cnt !== 16'd10) begin
         bad++; $display("FAIL mid_rst_run got=%0b/%0d want=0/10", halted, cnt);
      end
   endtask

   task test_saturate();
      applyReset();
      repeat (15) tick();
      total++;
      if (satCnt !== 4'd15) begin
         bad++; $display("FAIL sat_15 got=%0d want=15", satCnt);
      end
      repeat (5) tick();
      total++;
      if (satCnt !== 4'hF) begin
         bad++; $display("FAIL sat_20 got=%0d want=15", satCnt);
      end
      total++;
      if (cnt !== 16'd20) begin
         bad++; $display("FAIL sat_wide got=%0d want=20", cnt);
      end
   endtask

   task test_random();
      int hold;
      applyReset();
      i_bpAddr = AW'($urandom_range(0, 250));
      hold = 0;
      for (int k = 0; k < 3000; k++) begin
         if (hold == 0) begin
            i_button = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 14);
         end
         hold--;
         i_ctrlHlt = ($urandom_range(0, 39) == 0);
         i_bpEn = 1'($urandom_range(0, 1));
         i_pcAddr = i_bpAddr + AW'($urandom_range(0, 2));
         i_stepMode = 1'($urandom_range(0, 1));
         i_stepCount = SW'($urandom_range(0, 4));
         tick();
         total++;
         if (clkEn !== !mHalted || halted !== mHalted) begin
            bad++;
            $display("FAIL rnd_state cyc=%0d got=%0b/%0b want=%0b/%0b", k, clkEn, halted, !mHalted, mHalted);
         end
         total++;
         if (cause !== mCause) begin
            bad++; $display("FAIL rnd_cause cyc=%0d got=%0b want=%0b", k, cause, mCause);
         end
         total++;
         if (int'(cnt) !== expCnt(16) || int'(satCnt) !== expCnt(4)) begin
            bad++;
            $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", k, cnt, satCnt, expCnt(16), expCnt(4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_hlt();
      test_debounce();
      test_step();
      test_breakpoint();
      test_step_priority();
      test_reset_mid_step();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
